// File: rtl/arb_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arb_mux                                                      |
// | Description : N:1 data multiplexer with a one-entry registered output      |
// |               stage and valid/ready handshakes on every input and on the   |
// |               output. The source channel is picked either by an external   |
// |               select (MODE 0) or by round-robin arbitration over the       |
// |               valid inputs (MODE 1).                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   1             rising-edge clock                          |
// |   rst        in   1             synchronous active-high reset              |
// |   in_data    in   NUM_IN*WIDTH  channel i at [i*WIDTH +: WIDTH]            |
// |   in_valid   in   NUM_IN        per-channel valid                          |
// |   in_ready   out  NUM_IN        per-channel ready, at most one bit high    |
// |   sel        in   SEL_W         channel select (MODE 0 only)               |
// |   out_data   out  WIDTH         registered output data                     |
// |   out_valid  out  1             output register holds data                 |
// |   out_ready  in   1             consumer accepts out_data this cycle       |
// |   out_src    out  SEL_W         channel index that produced out_data       |
// +----------------------------------------------------------------------------+
module arb_mux #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src
);

    // Output register stage
    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [SEL_W-1:0]   r_src;

    // Channel choice and handshake
    logic               w_load;
    logic               w_pick_vld;
    logic [SEL_W-1:0]   w_pick;
    logic [NUM_IN-1:0]  w_ready;
    logic [WIDTH-1:0]   w_data;
    logic               w_xfer;

    // The output register can accept a new word when it is empty or is being
    // drained this very cycle, which gives back-to-back transfers.
    assign w_load = ~r_valid | out_ready;

    generate
        if (MODE == 1) begin : g_rr
            // Index of the channel with the highest priority next time round.
            logic [SEL_W-1:0] r_ptr;

            // Scan ptr, ptr+1, ... with wrap; the first valid channel wins.
            always_comb begin
                int v_idx;
                v_idx      = 0;
                w_pick_vld = 1'b0;
                w_pick     = '0;
                for (int k = 0; k < NUM_IN; k++) begin
                    v_idx = int'(r_ptr) + k;
                    if (v_idx >= NUM_IN) begin
                        v_idx = v_idx - NUM_IN;
                    end
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (!w_pick_vld && (i == v_idx) && in_valid[i]) begin
                            w_pick_vld = 1'b1;
                            w_pick     = SEL_W'(i);
                        end
                    end
                end
            end

            // The winner drops to lowest priority only once it has transferred.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_xfer) begin
                    if (int'(w_pick) == NUM_IN - 1) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= w_pick + 1'b1;
                    end
                end
            end
        end else begin : g_ext
            // External select; an out-of-range select chooses nothing.
            always_comb begin
                w_pick     = sel;
                w_pick_vld = 1'b0;
                for (int i = 0; i < NUM_IN; i++) begin
                    if (sel == SEL_W'(i)) begin
                        w_pick_vld = 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Decode the chosen channel into a one-hot ready and steer its data.
    always_comb begin
        w_ready = '0;
        w_data  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_pick_vld && (w_pick == SEL_W'(i))) begin
                w_ready[i] = w_load;
                w_data     = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer = |(w_ready & in_valid);

    // Data and source only change on a transfer, so they stay bit-stable
    // during backpressure and keep their last values after a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_data;
            r_src   <= w_pick;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_arb_mux                                                   |
// | Description : Scoreboard bench for arb_mux. Four instances share one       |
// |               stimulus stream: MODE 0 / MODE 1 with 4 channels and         |
// |               MODE 0 / MODE 1 with 3 channels. A reference model per       |
// |               instance predicts in_ready and queues expected words; a      |
// |               separate monitor checks the output register against them.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_arb_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [1:0]  sel = '0;
    logic        out_ready = 1'b0;
    bit          fin = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic check(input int j, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL inst%0d %s: got %0h expected %0h", j, nm, act, exp);
        end
    endtask

    // Reference choice: external select, or first valid channel at or after ptr.
    function automatic int pick(input int mode, input int nin, input int ptr,
                                input logic [3:0] v, input logic [1:0] s);
        if (mode == 0) begin
            return (int'(s) < nin) ? int'(s) : -1;
        end
        for (int k = 0; k < nin; k++) begin
            int c;
            c = (ptr + k) % nin;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    for (genvar j = 0; j < 4; j++) begin : g_inst
        localparam int NIN = (j < 2) ? 4 : 3;
        localparam int MD  = j % 2;

        logic [NIN-1:0] ir;
        logic [15:0]    od;
        logic           ov;
        logic [1:0]     os;

        logic [17:0] q[$];
        bit m_valid     = 1'b0;
        int m_ptr       = 0;
        bit m_after_rst = 1'b0;

        arb_mux #(
            .WIDTH  (16),
            .NUM_IN (NIN),
            .SEL_W  (2),
            .MODE   (MD)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data[NIN*16-1:0]),
            .in_valid  (in_valid[NIN-1:0]),
            .in_ready  (ir),
            .sel       (sel),
            .out_data  (od),
            .out_valid (ov),
            .out_ready (out_ready),
            .out_src   (os)
        );

        // Reference model: predicts ready and enqueues each accepted word.
        initial forever begin
            int         c;
            logic       ld;
            logic [3:0] er;
            @(negedge clk);
            if (rst) begin
                m_valid     = 1'b0;
                m_ptr       = 0;
                m_after_rst = 1'b1;
                q.delete();
            end else begin
                if (m_after_rst) begin
                    check(j, "rst_data", 32'(od), 32'h0);
                    check(j, "rst_src", 32'(os), 32'h0);
                    m_after_rst = 1'b0;
                end
                check(j, "out_valid", 32'(ov), 32'(m_valid));
                ld = !m_valid || out_ready;
                c  = pick(MD, NIN, m_ptr, in_valid, sel);
                er = (ld && c >= 0) ? 4'(1 << c) : 4'h0;
                check(j, "in_ready", 32'(ir), 32'(er));
                if (ld && c >= 0 && in_valid[c]) begin
                    q.push_back({2'(c), in_data[c*16 +: 16]});
                    m_valid = 1'b1;
                    if (MD == 1) m_ptr = (c + 1) % NIN;
                end else if (out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end

        // Monitor: whenever the output register holds a word it must be the
        // oldest undelivered one; it leaves the queue once accepted.
        initial forever begin
            @(negedge clk);
            if (!rst && ov === 1'b1) begin
                if (q.size() == 0) begin
                    check(j, "queue_level", 32'(q.size()), 32'd1);
                end else begin
                    check(j, "out_word", {14'b0, os, od}, {14'b0, q[0]});
                    if (out_ready) void'(q.pop_front());
                end
            end
        end

        initial begin
            wait (fin);
            @(negedge clk);
            check(j, "drain_empty", 32'(q.size()), 32'd0);
            check(j, "drain_valid", 32'(ov), 32'd0);
        end
    end

    task automatic drive(input logic r, input logic [3:0] v, input logic [1:0] s,
                         input logic ordy, input logic [63:0] d);
        @(posedge clk);
        #1;
        rst       = r;
        in_valid  = v;
        sel       = s;
        out_ready = ordy;
        in_data   = d;
    endtask

    localparam logic [63:0] C_D0 = {16'h3333, 16'h2222, 16'hBEEF, 16'h0000};
    localparam logic [63:0] C_D1 = {16'h3333, 16'h2222, 16'h1111, 16'h1234};
    localparam logic [63:0] C_DF = {16'h3333, 16'h2222, 16'h1111, 16'h0000};

    initial begin
        drive(1'b1, 4'h0, 2'd0, 1'b0, C_D0);
        drive(1'b0, 4'h0, 2'd0, 1'b1, C_D0);

        // Single select transfer of ch2
        drive(1'b0, 4'b0100, 2'd2, 1'b1, C_D0);
        drive(1'b0, 4'b0000, 2'd2, 1'b1, C_D0);

        // Load 1234 from ch0, stall three cycles while sel moves to 3, release
        drive(1'b0, 4'b0001, 2'd0, 1'b0, C_D1);
        drive(1'b0, 4'b1001, 2'd0, 1'b0, C_D1);
        drive(1'b0, 4'b1001, 2'd1, 1'b0, C_D1);
        drive(1'b0, 4'b1001, 2'd3, 1'b0, C_D1);
        drive(1'b0, 4'b1000, 2'd3, 1'b1, C_D1);
        drive(1'b0, 4'b0000, 2'd3, 1'b1, C_D1);

        // Out-of-range select on the 3-channel instances
        drive(1'b0, 4'b1111, 2'd3, 1'b1, C_DF);
        drive(1'b0, 4'b0111, 2'd3, 1'b1, C_DF);

        // All channels valid: round-robin rotation at full rate
        for (int i = 0; i < 8; i++) drive(1'b0, 4'hF, 2'd0, 1'b1, C_DF);

        // Sparse requests on ch1 and ch3
        for (int i = 0; i < 6; i++) drive(1'b0, 4'b1010, 2'd1, 1'b1, C_DF);

        // Reset during a stall discards the pending word and restarts at ch0
        drive(1'b0, 4'hF, 2'd1, 1'b0, C_DF);
        drive(1'b0, 4'hF, 2'd1, 1'b0, C_DF);
        drive(1'b1, 4'hF, 2'd1, 1'b0, C_DF);
        for (int i = 0; i < 4; i++) drive(1'b0, 4'hF, 2'd1, 1'b1, C_DF);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  4'($urandom),
                  2'($urandom),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  {$urandom, $urandom});
        end

        // Drain everything
        for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 2'd0, 1'b1, C_DF);
        fin = 1'b1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
